// File: rtl/tiger_decode_queue.sv
// tiger_decode_queue
//   Decode stage for the Tiger MIPS pipeline. Each fetched instruction is
//   decoded when it is accepted. The decoded entry goes into a DEPTH-entry
//   FIFO that sits between fetch and execute. Each entry is tagged with a
//   load-use hazard flag, and the whole queue can be flushed in a single
//   cycle on a branch redirect.
//
// Handshake: a transfer happens on a rising edge when valid && ready are both
//   high. Neither ready depends on valid in the same cycle. in_ready comes
//   from registered occupancy only, so a full queue refuses input even in a
//   cycle where the head is being consumed.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush               drop every entry and the hazard history; this
//                       cycle's input is lost
//   in_valid/in_ready   fetch handshake
//   in_instr, in_pc     instruction word and its address
//   out_valid/out_ready execute handshake for the head entry
//   out_instr, out_pc   head instruction and PC
//   out_controls        16-bit control word
//   out_alucontrol      ALU operation code
//   out_branchtype      branch condition code
//   out_destreg         destination register
//   out_loaduse         head reads the destination of the load enqueued
//                       just before it
//   count               occupancy, 0..DEPTH
module tiger_decode_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_WIDTH  = 32,
  parameter int HAZARD_EN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [PC_WIDTH-1:0]       in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [15:0]               out_controls,
  output logic [4:0]                out_alucontrol,
  output logic [2:0]                out_branchtype,
  output logic [4:0]                out_destreg,
  output logic                      out_loaduse,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // ALU operation codes
  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_LUI  = 5'd7;

  // Branch condition codes
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;

  // Control word bits: 13 regwrite, 12 alusrc (imm, dest=rt), 14 zero-ext
  // imm (dest=rt), 11 branch, 9 memtoreg, 8 memwrite, 7 jr, 6 jump, 5 link.
  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         controls;
    logic [4:0]          alu;
    logic [2:0]          br;
    logic [4:0]          dest;
    logic                loaduse;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_was_load_q, last_was_load_d;
  logic [4:0]    last_load_dest_q, last_load_dest_d;

  logic       push, pop;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       is_load, is_jump;
  entry_t     dec_entry, head;

  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign rd    = in_instr[15:11];
  assign funct = in_instr[5:0];

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Loads are every 100xxx opcode except 100111. Loads always write rt,
  // including the ones this decoder does not otherwise recognise.
  assign is_load = (op[5:3] == 3'b100) && (op != 6'b100111);
  assign is_jump = (op[5:1] == 5'b00001);

  always_comb begin
    dec_entry          = '0;
    dec_entry.instr    = in_instr;
    dec_entry.pc       = in_pc;
    dec_entry.alu      = ALU_NONE;
    dec_entry.br       = BR_NONE;
    case (op)
      6'h00: begin
        case (funct)
          6'h21: begin dec_entry.controls = 16'h2000; dec_entry.alu = ALU_ADD; end
          6'h23: begin dec_entry.controls = 16'h2000; dec_entry.alu = ALU_SUB; end
          6'h24: begin dec_entry.controls = 16'h2000; dec_entry.alu = ALU_AND; end
          6'h25: begin dec_entry.controls = 16'h2000; dec_entry.alu = ALU_OR;  end
          6'h26: begin dec_entry.controls = 16'h2000; dec_entry.alu = ALU_XOR; end
          6'h2A: begin dec_entry.controls = 16'h2000; dec_entry.alu = ALU_SLT; end
          6'h08: dec_entry.controls = 16'h0080;
          default: ;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) begin
          dec_entry.controls = 16'h0800; dec_entry.br = BR_BLTZ;
        end else if (rt == 5'd1) begin
          dec_entry.controls = 16'h0800; dec_entry.br = BR_BGEZ;
        end
      end
      6'h02: dec_entry.controls = 16'h0040;
      6'h03: dec_entry.controls = 16'h2060;
      6'h04: begin dec_entry.controls = 16'h0800; dec_entry.br = BR_BEQ;  end
      6'h05: begin dec_entry.controls = 16'h0800; dec_entry.br = BR_BNE;  end
      6'h06: begin dec_entry.controls = 16'h0800; dec_entry.br = BR_BLEZ; end
      6'h07: begin dec_entry.controls = 16'h0800; dec_entry.br = BR_BGTZ; end
      6'h09: begin dec_entry.controls = 16'h3000; dec_entry.alu = ALU_ADD; end
      6'h0A: begin dec_entry.controls = 16'h3000; dec_entry.alu = ALU_SLT; end
      6'h0C: begin dec_entry.controls = 16'h7000; dec_entry.alu = ALU_AND; end
      6'h0D: begin dec_entry.controls = 16'h7000; dec_entry.alu = ALU_OR;  end
      6'h0E: begin dec_entry.controls = 16'h7000; dec_entry.alu = ALU_XOR; end
      6'h0F: begin dec_entry.controls = 16'h6000; dec_entry.alu = ALU_LUI; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_entry.controls = 16'h3200; dec_entry.alu = ALU_ADD;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec_entry.controls = 16'h1100; dec_entry.alu = ALU_ADD;
      end
      default: ;
    endcase

    if (dec_entry.controls[5])
      dec_entry.dest = 5'd31;
    else if (dec_entry.controls[12] || dec_entry.controls[14])
      dec_entry.dest = rt;
    else
      dec_entry.dest = rd;

    dec_entry.loaduse = (HAZARD_EN != 0) && last_was_load_q &&
                        (last_load_dest_q != 5'd0) && !is_jump &&
                        ((rs == last_load_dest_q) || (rt == last_load_dest_q));
  end

  always_comb begin
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    last_was_load_d  = last_was_load_q;
    last_load_dest_d = last_load_dest_q;
    if (push) begin
      wr_ptr_d         = wr_ptr_q + AW'(1);
      last_was_load_d  = is_load;
      last_load_dest_d = is_load ? rt : 5'd0;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      last_was_load_q  <= 1'b0;
      last_load_dest_q <= 5'd0;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      last_was_load_q  <= last_was_load_d;
      last_load_dest_q <= last_load_dest_d;
    end
  end

  // Storage needs no reset: the outputs are forced to zero while the queue
  // is empty, and that covers the all-zero outputs required after reset.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= dec_entry;
  end

  assign head           = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_instr      = head.instr;
  assign out_pc         = head.pc;
  assign out_controls   = head.controls;
  assign out_alucontrol = head.alu;
  assign out_branchtype = head.br;
  assign out_destreg    = head.dest;
  assign out_loaduse    = head.loaduse;
  assign count          = count_q;

endmodule

// File: tb/tb_tiger_decode_queue.sv
module tb_tiger_decode_queue;

  localparam int DEPTH = 4;

  localparam logic [4:0] ALU_NONE = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2,
                         ALU_AND = 5'd3, ALU_OR = 5'd4, ALU_XOR = 5'd5,
                         ALU_SLT = 5'd6, ALU_LUI = 5'd7;
  localparam logic [2:0] BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2,
                         BR_BLEZ = 3'd3, BR_BGTZ = 3'd4, BR_BLTZ = 3'd5,
                         BR_BGEZ = 3'd6;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_loaduse;
  logic [31:0] out_instr, out_pc;
  logic [15:0] out_controls;
  logic [4:0]  out_alucontrol, out_destreg;
  logic [2:0]  out_branchtype;
  logic [2:0]  count;

  logic        nh_in_ready, nh_out_valid, nh_out_loaduse;
  logic [31:0] nh_out_instr, nh_out_pc;
  logic [15:0] nh_out_controls;
  logic [4:0]  nh_out_alucontrol, nh_out_destreg;
  logic [2:0]  nh_out_branchtype;
  logic [2:0]  nh_count;

  always #5 clk = ~clk;

  tiger_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .HAZARD_EN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_controls(out_controls), .out_alucontrol(out_alucontrol),
    .out_branchtype(out_branchtype), .out_destreg(out_destreg),
    .out_loaduse(out_loaduse), .count(count)
  );

  tiger_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .HAZARD_EN(0)) dut_nh (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(nh_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(nh_out_valid), .out_ready(out_ready), .out_instr(nh_out_instr),
    .out_pc(nh_out_pc), .out_controls(nh_out_controls),
    .out_alucontrol(nh_out_alucontrol), .out_branchtype(nh_out_branchtype),
    .out_destreg(nh_out_destreg), .out_loaduse(nh_out_loaduse), .count(nh_count)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic [4:0]  alu;
    logic [2:0]  br;
    logic [4:0]  dest;
    logic        lu;
  } exp_t;

  exp_t       exp_q[$];
  logic       m_last_load;
  logic [4:0] m_load_dest;
  logic       after_reset;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Mnemonic-level view of the Tiger decode table.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    op = w[31:26];
    fn = w[5:0];
    rt = w[20:16];
    e = '0;
    e.instr = w;
    e.pc = pc;
    e.alu = ALU_NONE;
    e.br = BR_NONE;
    if (op == 6'h00) begin
      if (fn == 6'h08) e.ctrl = 16'h0080;
      else if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A}) begin
        e.ctrl = 16'h2000;
        e.alu = (fn == 6'h21) ? ALU_ADD : (fn == 6'h23) ? ALU_SUB :
                (fn == 6'h24) ? ALU_AND : (fn == 6'h25) ? ALU_OR  :
                (fn == 6'h26) ? ALU_XOR : ALU_SLT;
      end
    end else if (op == 6'h01 && rt <= 5'd1) begin
      e.ctrl = 16'h0800;
      e.br = (rt == 5'd0) ? BR_BLTZ : BR_BGEZ;
    end else if (op >= 6'h04 && op <= 6'h07) begin
      e.ctrl = 16'h0800;
      e.br = (op == 6'h04) ? BR_BEQ : (op == 6'h05) ? BR_BNE :
             (op == 6'h06) ? BR_BLEZ : BR_BGTZ;
    end else if (op == 6'h02) e.ctrl = 16'h0040;
    else if (op == 6'h03) e.ctrl = 16'h2060;
    else if (op == 6'h09) begin e.ctrl = 16'h3000; e.alu = ALU_ADD; end
    else if (op == 6'h0A) begin e.ctrl = 16'h3000; e.alu = ALU_SLT; end
    else if (op == 6'h0C) begin e.ctrl = 16'h7000; e.alu = ALU_AND; end
    else if (op == 6'h0D) begin e.ctrl = 16'h7000; e.alu = ALU_OR;  end
    else if (op == 6'h0E) begin e.ctrl = 16'h7000; e.alu = ALU_XOR; end
    else if (op == 6'h0F) begin e.ctrl = 16'h6000; e.alu = ALU_LUI; end
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin e.ctrl = 16'h3200; e.alu = ALU_ADD; end
    else if (op inside {6'h28, 6'h29, 6'h2B}) begin e.ctrl = 16'h1100; e.alu = ALU_ADD; end
    if (e.ctrl[5]) e.dest = 5'd31;
    else if (e.ctrl[12] || e.ctrl[14]) e.dest = rt;
    else e.dest = w[15:11];
    return e;
  endfunction

  task automatic check_outputs();
    exp_t h;
    check("count", count, exp_q.size());
    check("out_valid", out_valid, exp_q.size() > 0);
    check("in_ready", in_ready, exp_q.size() < DEPTH);
    check("nh_count", nh_count, exp_q.size());
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check("head_instr", out_instr, h.instr);
      check("head_pc", out_pc, h.pc);
      check("head_controls", out_controls, h.ctrl);
      check("head_alu", out_alucontrol, h.alu);
      check("head_branch", out_branchtype, h.br);
      check("head_dest", out_destreg, h.dest);
      check("head_loaduse", out_loaduse, h.lu);
      check("nh_head_pc", nh_out_pc, h.pc);
      check("nh_loaduse", nh_out_loaduse, 1'b0);
    end else if (after_reset) begin
      check("rst_data", {out_instr, out_pc}, 64'd0);
      check("rst_ctrl", {out_controls, out_alucontrol, out_branchtype,
                         out_destreg, out_loaduse}, 64'd0);
    end
  endtask

  // One clock: check settled outputs, drive inputs, update model on the edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic rst);
    exp_t e;
    logic acc, pp;
    check_outputs();
    in_valid = v; in_instr = w; in_pc = pc;
    out_ready = rdy; flush = fl; reset = rst;
    @(posedge clk);
    if (rst || fl) begin
      exp_q.delete();
      m_last_load = 1'b0;
      m_load_dest = 5'd0;
      if (rst) after_reset = 1'b1;
    end else begin
      acc = v && (exp_q.size() < DEPTH);
      pp  = rdy && (exp_q.size() > 0);
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        e = ref_decode(w, pc);
        e.lu = m_last_load && (m_load_dest != 0) && (w[31:27] != 5'b00001) &&
               (w[25:21] == m_load_dest || w[20:16] == m_load_dest);
        exp_q.push_back(e);
        m_last_load = (w[31:29] == 3'b100) && (w[31:26] != 6'b100111);
        m_load_dest = w[20:16];
        after_reset = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                             6'h06, 6'h07, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h20, 6'h24,
                             6'h22, 6'h2B, 6'h27, 6'h3F};
    logic [5:0] fns [7] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h3F};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 19)];
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = (w[31:26] == 6'h01) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 7));
    w[15:11] = 5'($urandom_range(0, 7));
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 6)];
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    exp_q.delete();
    m_last_load = 1'b0; m_load_dest = 5'd0; after_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset state and single ADDU
    cycle(1'b1, 32'h00221821, 32'h100, 1'b0, 1'b0, 1'b0);
    check("addu_controls", out_controls, 16'h2000);
    check("addu_dest", out_destreg, 5'd3);
    check("addu_pc", out_pc, 32'h100);
    check("addu_count", count, 1);
    idle(1'b1, 1);

    // Fill past DEPTH with out_ready low
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(1'b1, 32'h00221821 | (i << 11), 32'h200 + 4 * i, 1'b0, 1'b0, 1'b0);
    check("full_count", count, DEPTH);
    check("full_ready", in_ready, 1'b0);
    cycle(1'b1, 32'h00223821, 32'h214, 1'b1, 1'b0, 1'b0);
    check("pop_no_push", count, DEPTH - 1);
    cycle(1'b1, 32'h00223821, 32'h214, 1'b0, 1'b0, 1'b0);
    check("late_push", count, DEPTH);
    idle(1'b1, DEPTH);

    // Load-use: LW r5 then ADDU r6,r5,r1
    cycle(1'b1, 32'h8C850008, 32'h300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A13021, 32'h304, 1'b0, 1'b0, 1'b0);
    check("lw_controls", out_controls, 16'h3200);
    check("lw_dest", out_destreg, 5'd5);
    check("lw_loaduse", out_loaduse, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("user_loaduse", out_loaduse, 1'b1);
    check("nh_user_loaduse", nh_out_loaduse, 1'b0);
    idle(1'b1, 1);

    // LW r0 then user of r0; LW r5 then J with r5 in its field bits
    cycle(1'b1, 32'h8C800008, 32'h400, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00013021, 32'h404, 1'b1, 1'b0, 1'b0);
    check("r0_loaduse", out_loaduse, 1'b0);
    cycle(1'b1, 32'h8C850008, 32'h408, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h08A50000, 32'h40C, 1'b1, 1'b0, 1'b0);
    check("j_loaduse", out_loaduse, 1'b0);
    check("j_controls", out_controls, 16'h0040);
    idle(1'b1, 1);

    // Flush with 3 entries, LW last, while pushing and popping
    cycle(1'b1, 32'h00221821, 32'h500, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00221821, 32'h504, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h8C850008, 32'h508, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A13021, 32'h50C, 1'b1, 1'b1, 1'b0);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 1'b0);
    cycle(1'b1, 32'h00A13021, 32'h510, 1'b0, 1'b0, 1'b0);
    check("flush_history", out_loaduse, 1'b0);
    check("flush_pc", out_pc, 32'h510);
    idle(1'b1, 1);

    // Randomized streaming across many pointer wraps
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), 32'h1000 + 4 * i,
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, 1'b0);

    // Reset mid-stream
    cycle(1'b1, 32'h00221821, 32'h2000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00221821, 32'h2004, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00221821, 32'h2008, 1'b1, 1'b0, 1'b1);
    check("midrst_count", count, 0);
    check("midrst_valid", out_valid, 1'b0);
    idle(1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tiger_decode_queue.md
Name: tiger_decode_queue

Overview:
Parametrised decode stage for the Tiger MIPS pipeline. It accepts fetched instructions over a valid/ready handshake and decodes each one at enqueue time into the standard Tiger control bundle (controls, alucontrol, branchtype, destreg). Decoded entries are buffered in a DEPTH-entry FIFO that decouples fetch from execute. The block adds optional load-use hazard tagging, occupancy reporting and a single-cycle flush for branch redirect.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
PC_WIDTH, 32, width of the PC carried with each instruction
HAZARD_EN, 1, 1 enables load-use tagging; 0 forces out_loaduse to 0

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all entries and hazard history this cycle
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; equals !full, registered-state derived
in_instr  in  32  instruction word
in_pc  in  PC_WIDTH  instruction address
out_valid  out  1  head entry valid (!empty)
out_ready  in  1  execute consumes the head this cycle
out_instr  out  32  head instruction word
out_pc  out  PC_WIDTH  head PC
out_controls  out  16  head decoded control word
out_alucontrol  out  5  head ALU code (tiger_defines encoding)
out_branchtype  out  3  head branch code
out_destreg  out  5  head destination register
out_loaduse  out  1  head reads the destreg of the preceding load
count  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset (synchronous, active-high) and flush: rd_ptr=wr_ptr=0, count=0, last_was_load=0, last_load_dest=0. After reset: out_valid=0, in_ready=1, and all out_* data fields are 0. Flush takes priority over enqueue and dequeue in the same cycle; the input on that cycle is dropped.
- Enqueue when in_valid && in_ready && !flush. Dequeue when out_valid && out_ready && !flush. Both may occur in the same cycle; count is unchanged in that case.
- in_ready is derived from stored state only: no combinational path from out_ready, so a full queue rejects input even during a simultaneous dequeue.
- Latency: an instruction accepted at edge N is visible at the head at edge N+1 if the queue was empty (out_valid rises one cycle after acceptance). No bypass path exists.
- Output data reflects the head entry combinationally from storage. Contents when out_valid=0 are don't-care, except immediately after reset, when they are 0.
- Pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.
- Decode rules (standard Tiger encoding):
  - R-type ADDU: controls=0x2000.
  - LW: controls=0x3200, alucontrol=ALU_ADD.
  - JR: controls=0x0080.
  - JAL: destreg=31.
  - BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ: controls=0x0800 with branchtype per the Tiger branch table.
  - Unknown op: controls=0, alucontrol=ALU_NONE, branchtype=BR_NONE.
  - destreg = 31 if controls[5]; else rt if controls[12] or controls[14]; else rd.
- Hazard tag (HAZARD_EN=1), computed at enqueue against the previously enqueued instruction:
  - loaduse = last_was_load && last_load_dest!=0 && (rs==last_load_dest || rt==last_load_dest).
  - The comparison is skipped (loaduse=0) for J/JAL (op 00001x).
  - is_load = op[5:3]==3'b100 and op!=6'b100111.
  - Each enqueue updates last_was_load and last_load_dest. A cycle without enqueue leaves them unchanged.
  - Flush and reset clear the history.
- Reset asserted mid-stream discards all entries with no further output.

Test Plan:
- Reset, then enqueue 0x00221821 (ADDU r3,r1,r2) with pc 0x100 -> next cycle out_valid=1, out_controls=0x2000, out_destreg=3, out_pc=0x100, count=1.
- Hold out_ready=0 and push DEPTH+1 instructions -> in_ready falls after 4 accepts, the fifth is held, count=4. Then assert out_ready for one cycle with in_valid=1 -> one pop, no push, count=3. The push lands on the following cycle.
- Enqueue LW r5,8(r4) (0x8C850008), then ADDU r6,r5,r1 (0x00A13021) -> head1: controls=0x3200, destreg=5, loaduse=0; head2: loaduse=1. Repeat with HAZARD_EN=0 -> loaduse=0.
- LW r0 followed by a user of r0 -> loaduse=0. LW r5 followed by J -> loaduse=0.
- Fill 3 entries, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, nothing popped or pushed, hazard history cleared.
- Run 3*DEPTH streaming push/pop pairs with random out_ready -> output order and PCs match input order across pointer wrap-around; assert reset mid-stream -> count=0 next cycle.
